hub75_scan_ctrl: RTL and testbench

- Scan sequencer for the LED matrix panel (HUB75-style, dual-scan: upper/lower half driven simultaneously).
- Fetches bit-plane pixel data from the frame buffer read port and shifts it into the panel column drivers.
- Generates latch, output-enable, row-address and shift-clock timing, using binary-coded modulation (BCM) for brightness.
- Sits between the frame buffer and the panel pins in the top level.

---
 rtl/hub75_scan_ctrl_if.sv | 35 +++
 rtl/hub75_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_scan_ctrl_if.sv
// Frame-buffer read port and HUB75 panel pins of the scan sequencer.
// master = scan controller, slave = frame buffer / panel side.
interface hub75_scan_ctrl_if #(
  parameter int unsigned COLS          = 32,
  parameter int unsigned ROW_ADDR_BITS = 4,
  parameter int unsigned BPC           = 4
);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned BIT_W = $clog2(BPC);

  logic                     enable;
  logic                     pix_rd_en;
  logic [ROW_ADDR_BITS-1:0] pix_rd_row;
  logic [COL_W-1:0]         pix_rd_col;
  logic [BIT_W-1:0]         pix_rd_bit;
  logic [5:0]               pix_rd_data;
  logic                     hub_clk;
  logic                     hub_lat;
  logic                     hub_oe_;
  logic [ROW_ADDR_BITS-1:0] hub_addr;
  logic [5:0]               hub_rgb;
  logic                     frame_done;

  modport master (
    input  enable, pix_rd_data,
    output pix_rd_en, pix_rd_row, pix_rd_col, pix_rd_bit,
    output hub_clk, hub_lat, hub_oe_, hub_addr, hub_rgb, frame_done
  );

  modport slave (
    output enable, pix_rd_data,
    input  pix_rd_en, pix_rd_row, pix_rd_col, pix_rd_bit,
    input  hub_clk, hub_lat, hub_oe_, hub_addr, hub_rgb, frame_done
  );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 dual-scan sequencer: shifts one bit plane per row from the frame
// buffer, then latches and lights it for BASE_CYCLES<<plane cycles (BCM).
module hub75_scan_ctrl #(
  parameter int unsigned COLS          = 32,
  parameter int unsigned ROW_ADDR_BITS = 4,
  parameter int unsigned BPC           = 4,
  parameter int unsigned BASE_CYCLES   = 8
) (
  input  logic                clk,
  input  logic                reset,
  hub75_scan_ctrl_if.master   bus
);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned BIT_W = $clog2(BPC);
  localparam int unsigned CNT_W = $clog2(BASE_CYCLES << (BPC - 1)) + 1;

  localparam logic [COL_W-1:0]         COL_LAST = COL_W'(COLS - 1);
  localparam logic [BIT_W-1:0]         BIT_LAST = BIT_W'(BPC - 1);
  localparam logic [ROW_ADDR_BITS-1:0] ROW_LAST = '1;

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;
  typedef enum logic [1:0] {P0, P1, P2} phase_t;

  state_t                   state, state_nxt;
  phase_t                   phase, phase_nxt;
  logic [COL_W-1:0]         col, col_nxt;
  logic [ROW_ADDR_BITS-1:0] row, row_nxt;
  logic [BIT_W-1:0]         plane, plane_nxt;
  logic [CNT_W-1:0]         dcnt, dcnt_nxt;

  logic                     rd_en_q, rd_en_d;
  logic [ROW_ADDR_BITS-1:0] rd_row_q, rd_row_d;
  logic [COL_W-1:0]         rd_col_q, rd_col_d;
  logic [BIT_W-1:0]         rd_bit_q, rd_bit_d;
  logic                     hclk_q, hclk_d;
  logic                     lat_q, lat_d;
  logic                     oe_q, oe_d;
  logic [ROW_ADDR_BITS-1:0] addr_q, addr_d;
  logic [5:0]               rgb_q, rgb_d;
  logic                     done_q, done_d;

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= P0;
      col      <= '0;
      row      <= '0;
      plane    <= '0;
      dcnt     <= '0;
      rd_en_q  <= 1'b0;
      rd_row_q <= '0;
      rd_col_q <= '0;
      rd_bit_q <= '0;
      hclk_q   <= 1'b0;
      lat_q    <= 1'b0;
      oe_q     <= 1'b1;
      addr_q   <= '0;
      rgb_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      col      <= col_nxt;
      row      <= row_nxt;
      plane    <= plane_nxt;
      dcnt     <= dcnt_nxt;
      rd_en_q  <= rd_en_d;
      rd_row_q <= rd_row_d;
      rd_col_q <= rd_col_d;
      rd_bit_q <= rd_bit_d;
      hclk_q   <= hclk_d;
      lat_q    <= lat_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      rgb_q    <= rgb_d;
      done_q   <= done_d;
    end
  end

  // Next state; a plane always runs to completion, enable is only sampled
  // in IDLE and on the last DISPLAY cycle.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    col_nxt   = col;
    row_nxt   = row;
    plane_nxt = plane;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_nxt = SHIFT;
          phase_nxt = P0;
          col_nxt   = '0;
        end
      end
      SHIFT: begin
        case (phase)
          P0:      phase_nxt = P1;
          P1:      phase_nxt = P2;
          default: begin
            phase_nxt = P0;
            if (col == COL_LAST) state_nxt = BLANK;
            else                 col_nxt   = col + COL_W'(1);
          end
        endcase
      end
      BLANK: state_nxt = LATCH;
      LATCH: begin
        state_nxt = DISPLAY;
        dcnt_nxt  = CNT_W'(BASE_CYCLES) << plane;
      end
      DISPLAY: begin
        if (dcnt == CNT_W'(1)) begin
          if (plane == BIT_LAST) begin
            plane_nxt = '0;
            row_nxt   = row + ROW_ADDR_BITS'(1);
          end else begin
            plane_nxt = plane + BIT_W'(1);
          end
          state_nxt = bus.enable ? SHIFT : IDLE;
          phase_nxt = P0;
          col_nxt   = '0;
        end else begin
          dcnt_nxt = dcnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered pins line up with it
  always_comb begin
    rd_en_d  = (state_nxt == SHIFT) && (phase_nxt == P0);
    rd_row_d = row_nxt;
    rd_col_d = col_nxt;
    rd_bit_d = plane_nxt;
    hclk_d   = (state_nxt == SHIFT) && (phase_nxt == P2);
    lat_d    = (state_nxt == LATCH);
    oe_d     = (state_nxt != DISPLAY);
    addr_d   = (state_nxt == BLANK) ? row_nxt : addr_q;
    rgb_d    = ((state == SHIFT) && (phase == P1)) ? bus.pix_rd_data : rgb_q;
    done_d   = (state_nxt == DISPLAY) && (dcnt_nxt == CNT_W'(1)) &&
               (plane_nxt == BIT_LAST) && (row_nxt == ROW_LAST);
  end

  assign bus.pix_rd_en  = rd_en_q;
  assign bus.pix_rd_row = rd_row_q;
  assign bus.pix_rd_col = rd_col_q;
  assign bus.pix_rd_bit = rd_bit_q;
  assign bus.hub_clk    = hclk_q;
  assign bus.hub_lat    = lat_q;
  assign bus.hub_oe_    = oe_q;
  assign bus.hub_addr   = addr_q;
  assign bus.hub_rgb    = rgb_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl (COLS=4, 2 rows, 2 planes, BASE_CYCLES=2):
// first-plane vector table plus plane/offset timing model for the long runs.
module tb_hub75_scan_ctrl;
  localparam int unsigned COLS = 4;
  localparam int unsigned RAB  = 1;
  localparam int unsigned BPC  = 2;
  localparam int unsigned BASE = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hub75_scan_ctrl_if #(.COLS(COLS), .ROW_ADDR_BITS(RAB), .BPC(BPC)) bus ();

  hub75_scan_ctrl #(.COLS(COLS), .ROW_ADDR_BITS(RAB), .BPC(BPC), .BASE_CYCLES(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [5:0] fb(input logic r, input logic [1:0] c, input logic b);
    logic [5:0] base;
    case (c)
      2'd0:    base = 6'b101010;
      2'd1:    base = 6'b010101;
      2'd2:    base = 6'b111000;
      default: base = 6'b000111;
    endcase
    return base ^ {4'b0000, r, b};
  endfunction

  // Frame buffer: data one cycle after the read strobe
  always @(posedge clk) begin
    if (bus.pix_rd_en) bus.pix_rd_data <= fb(bus.pix_rd_row, bus.pix_rd_col, bus.pix_rd_bit);
  end

  int n_chk = 0;
  int n_fail = 0;
  int gc = 0;

  // Model: idle flag, plane index (row*2+bit), offset inside the plane
  logic       m_idle;
  int         m_pl;
  int         m_o;
  logic       m_addr;
  logic [5:0] m_rgb;
  logic       prev_addr;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", nm, gc, act, exp);
    end
  endtask

  function automatic int plane_len(input int b);
    return 3 * COLS + 2 + (BASE << b);
  endfunction

  // {rd_en, rd_row, rd_col[1:0], rd_bit, hub_clk, hub_lat, hub_oe_, hub_addr, hub_rgb[5:0], frame_done}
  function automatic logic [15:0] act_vec();
    logic rd;
    rd = bus.pix_rd_en;
    return {rd, rd ? bus.pix_rd_row : 1'b0, rd ? bus.pix_rd_col : 2'b00, rd ? bus.pix_rd_bit : 1'b0,
            bus.hub_clk, bus.hub_lat, bus.hub_oe_, bus.hub_addr, bus.hub_rgb, bus.frame_done};
  endfunction

  function automatic logic [15:0] model_vec();
    int   row, b, len;
    logic rd;
    row = m_pl / 2;
    b   = m_pl % 2;
    len = plane_len(b);
    if (m_idle) return {7'b0000000, 1'b1, m_addr, m_rgb, 1'b0};
    rd = (m_o < 12) && (m_o % 3 == 0);
    return {rd, rd ? 1'(row) : 1'b0, rd ? 2'(m_o / 3) : 2'b00, rd ? 1'(b) : 1'b0,
            1'((m_o < 12) && (m_o % 3 == 2)), 1'(m_o == 13), 1'(m_o < 14),
            m_addr, m_rgb, 1'((m_pl == 3) && (m_o == len - 1))};
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_pl = 0; m_o = 0; m_addr = 1'b0; m_rgb = 6'd0; prev_addr = 1'b0;
  endtask

  task automatic advance();
    int row, b;
    if (m_idle) begin
      if (bus.enable) begin m_idle = 1'b0; m_o = 0; end
    end else if (m_o == plane_len(m_pl % 2) - 1) begin
      m_pl = (m_pl + 1) % 4; m_o = 0; m_idle = !bus.enable;
    end else begin
      m_o++;
    end
    row = m_pl / 2;
    b   = m_pl % 2;
    if (!m_idle && m_o == 12) m_addr = 1'(row);
    if (!m_idle && m_o < 12 && m_o % 3 == 2) m_rgb = fb(1'(row), 2'(m_o / 3), 1'(b));
  endtask

  task automatic tick();
    advance();
    @(negedge clk);
    gc++;
  endtask

  task automatic chk_model();
    chk("model", act_vec(), model_vec());
    chk("lat with oe on", 16'(bus.hub_lat & ~bus.hub_oe_), 16'd0);
    chk("clk with lat", 16'(bus.hub_clk & bus.hub_lat), 16'd0);
    if (bus.hub_addr !== prev_addr) chk("addr change while lit", 16'(bus.hub_oe_), 16'd1);
    prev_addr = bus.hub_addr;
  endtask

  typedef struct {
    logic       en;
    logic       rd_en;
    logic [1:0] col;
    logic       bitp;
    logic       hclk;
    logic       lat;
    logic       oe_n;
    logic [5:0] rgb;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int fd_cnt, fd_first, fd_last, w, oe_lo, lat_cnt;
    logic [15:0] exp;

    // Row 0 plane 0, from the first SHIFT cycle through the first P0 of plane 1
    tbl[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b101010};
    tbl[3]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b101010};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b101010};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b010101};
    tbl[6]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 6'b010101};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b010101};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b111000};
    tbl[9]  = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111000};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111000};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b000111};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000111};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000111};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000111};
    tbl[15] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000111};
    tbl[16] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b000111};

    reset = 1'b1;
    bus.enable = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset outputs", act_vec(), 16'h0100);
    chk("reset rd address", 16'({bus.pix_rd_row, bus.pix_rd_col, bus.pix_rd_bit}), 16'd0);

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin chk_model(); tick(); end

    // Enable is seen on the next edge; the cycle after it is the first P0
    bus.enable = 1'b1;
    tick();
    gc = 0;
    for (int i = 0; i < 17; i++) begin
      exp = {tbl[i].rd_en, 1'b0, tbl[i].col, tbl[i].bitp, tbl[i].hclk, tbl[i].lat,
             tbl[i].oe_n, 1'b0, tbl[i].rgb, 1'b0};
      chk($sformatf("table[%0d]", i), act_vec(), exp);
      bus.enable = tbl[i].en;
      tick();
    end

    // Two full frames under the model; frame_done every 68 cycles
    fd_cnt = 0; fd_first = -1; fd_last = -1;
    for (int k = 0; k < 134; k++) begin
      chk_model();
      if (bus.frame_done) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = gc; else fd_last = gc;
      end
      tick();
    end
    chk("frame_done count", 16'(fd_cnt), 16'd2);
    chk("frame_done first", 16'(fd_first), 16'd67);
    chk("frame_done period", 16'(fd_last - fd_first), 16'd68);

    // Drop enable during SHIFT of row 1 plane 0
    w = 0;
    while (!(!m_idle && m_pl == 2 && m_o == 3) && w < 300) begin chk_model(); tick(); w++; end
    if (w >= 300) begin n_chk++; n_fail++; $display("FAIL wait row1 plane0: timeout after %0d cycles", w); end
    bus.enable = 1'b0;
    oe_lo = 0; lat_cnt = 0; w = 0;
    while (!m_idle && w < 100) begin
      chk_model();
      oe_lo += int'(!bus.hub_oe_);
      lat_cnt += int'(bus.hub_lat);
      tick(); w++;
    end
    chk("drop: oe cycles", 16'(oe_lo), 16'd2);
    chk("drop: latch pulses", 16'(lat_cnt), 16'd1);
    for (int i = 0; i < 4; i++) begin chk_model(); tick(); end

    // Resume at row 1 plane 1
    bus.enable = 1'b1;
    tick();
    chk("resume read", 16'({bus.pix_rd_en, bus.pix_rd_row, bus.pix_rd_bit, bus.pix_rd_col}), 16'b11100);
    w = 0;
    while (!(!m_idle && m_pl == 2 && m_o == 14) && w < 300) begin chk_model(); tick(); w++; end
    if (w >= 300) begin n_chk++; n_fail++; $display("FAIL wait display: timeout after %0d cycles", w); end
    chk_model();

    // Asynchronous reset in the middle of a lit plane
    #2 reset = 1'b1;
    #1;
    chk("async reset pins", 16'({bus.hub_oe_, bus.hub_addr, bus.hub_rgb, bus.hub_lat,
                                 bus.pix_rd_en, bus.frame_done, bus.hub_clk}), 16'h0800);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    chk_model();
    tick();
    chk("restart read", 16'({bus.pix_rd_en, bus.pix_rd_row, bus.pix_rd_bit, bus.pix_rd_col}), 16'b10000);
    for (int i = 0; i < 40; i++) begin chk_model(); tick(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
